// File: rtl/audio_nios_nios_cpu_trace_capture.sv
// audio_nios_nios_cpu_trace_capture: arm/trigger/post-count trace capture into a circular buffer with debug read-back.
// Revision 1.0
`default_nettype none

module audio_nios_nios_cpu_trace_capture #(
  parameter int TRC_DEPTH = 128,
  localparam int AW = $clog2(TRC_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [35:0]   trc_word,
  input  logic          trc_word_valid,
  input  logic          trc_trigger,
  input  logic          take_action_tracectrl,
  input  logic [37:0]   jdo,
  input  logic          rd_addr_load,
  input  logic          rd_next,
  output logic [35:0]   tracemem_trcdata,
  output logic          tracemem_tw,
  output logic [AW-1:0] trc_im_addr,
  output logic          trc_wrap,
  output logic          trc_on,
  output logic          tracemem_on,
  output logic          trigger_state_1
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  trc_im_addr_q, trc_im_addr_d;
  logic           trc_wrap_q, trc_wrap_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]     post_arm_q, post_arm_d;
  logic [7:0]     post_cnt_q, post_cnt_d;
  logic [35:0]    trcdata_q, trcdata_d;
  logic           tw_q, tw_d;
  logic           trc_on_q, trc_on_d;
  logic           trig1_q, trig1_d;

  logic [35:0]    mem [TRC_DEPTH];

  logic           ctl_arm, ctl_clear, ctl_stop;
  logic           wr_en;
  logic           rd_req;
  logic [AW-1:0]  rd_addr;
  logic           unused_jdo;

  assign ctl_arm   = take_action_tracectrl & jdo[0];
  assign ctl_clear = take_action_tracectrl & jdo[1];
  assign ctl_stop  = take_action_tracectrl & jdo[2];
  assign unused_jdo = ^jdo;

  // A clear in the same cycle discards the incoming word entirely.
  assign wr_en = trc_word_valid & ~ctl_clear &
                 ((state_q == ST_ARMED) | (state_q == ST_CAPTURE));

  assign rd_req  = rd_addr_load | rd_next;
  assign rd_addr = rd_addr_load ? jdo[16 +: AW] : rd_ptr_q;

  always_comb begin
    state_d    = state_q;
    post_arm_d = post_arm_q;
    post_cnt_d = post_cnt_q;

    case (state_q)
      ST_ARMED: begin
        if (trc_trigger) begin
          state_d    = ST_CAPTURE;
          post_cnt_d = post_arm_q;
        end
      end
      ST_CAPTURE: begin
        if (wr_en) begin
          if (post_cnt_q <= 8'd1) state_d = ST_STOPPED;
          post_cnt_d = (post_cnt_q == 8'd0) ? 8'd0 : post_cnt_q - 8'd1;
        end
      end
      default: ;
    endcase

    if (ctl_stop) begin
      state_d = ST_STOPPED;
    end else if (ctl_arm && (state_q == ST_IDLE || state_q == ST_STOPPED)) begin
      state_d    = ST_ARMED;
      post_arm_d = jdo[15:8];
    end

    trc_on_d = (state_d == ST_ARMED) | (state_d == ST_CAPTURE);
    trig1_d  = (state_d == ST_CAPTURE);
  end

  always_comb begin
    trc_im_addr_d = trc_im_addr_q;
    trc_wrap_d    = trc_wrap_q;
    if (ctl_clear) begin
      trc_im_addr_d = '0;
      trc_wrap_d    = 1'b0;
    end else if (wr_en) begin
      trc_im_addr_d = trc_im_addr_q + AW'(1);
      if (&trc_im_addr_q) trc_wrap_d = 1'b1;
    end
  end

  // Memory reads see the pre-edge contents, giving read-before-write.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    trcdata_d = trcdata_q;
    tw_d      = rd_req;
    if (rd_req) begin
      trcdata_d = mem[rd_addr];
      rd_ptr_d  = rd_addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[trc_im_addr_q] <= trc_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      trc_im_addr_q <= '0;
      trc_wrap_q    <= 1'b0;
      rd_ptr_q      <= '0;
      post_arm_q    <= 8'd0;
      post_cnt_q    <= 8'd0;
      trcdata_q     <= 36'd0;
      tw_q          <= 1'b0;
      trc_on_q      <= 1'b0;
      trig1_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      trc_im_addr_q <= trc_im_addr_d;
      trc_wrap_q    <= trc_wrap_d;
      rd_ptr_q      <= rd_ptr_d;
      post_arm_q    <= post_arm_d;
      post_cnt_q    <= post_cnt_d;
      trcdata_q     <= trcdata_d;
      tw_q          <= tw_d;
      trc_on_q      <= trc_on_d;
      trig1_q       <= trig1_d;
    end
  end

  assign tracemem_trcdata = trcdata_q;
  assign tracemem_tw      = tw_q;
  assign trc_im_addr      = trc_im_addr_q;
  assign trc_wrap         = trc_wrap_q;
  assign trc_on           = trc_on_q;
  assign trigger_state_1  = trig1_q;
  assign tracemem_on      = (trc_im_addr_q != '0) | trc_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_nios_nios_cpu_trace_capture.sv
// tb_audio_nios_nios_cpu_trace_capture: directed vectors with hand-computed expectations.
`default_nettype none

module tb_audio_nios_nios_cpu_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [35:0] trc_word;
  logic        trc_word_valid;
  logic        trc_trigger;
  logic        take_action_tracectrl;
  logic [37:0] jdo;
  logic        rd_addr_load;
  logic        rd_next;
  logic [35:0] tracemem_trcdata;
  logic        tracemem_tw;
  logic [6:0]  trc_im_addr;
  logic        trc_wrap;
  logic        trc_on;
  logic        tracemem_on;
  logic        trigger_state_1;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [35:0] PRE  = 36'hA00000000;
  localparam logic [35:0] POST = 36'hB00000000;
  localparam logic [35:0] WX   = 36'hC00000000;
  localparam logic [35:0] XW   = 36'h123456789;
  localparam logic [35:0] YW   = 36'h0DEADBEEF;

  audio_nios_nios_cpu_trace_capture dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .trc_word              (trc_word),
    .trc_word_valid        (trc_word_valid),
    .trc_trigger           (trc_trigger),
    .take_action_tracectrl (take_action_tracectrl),
    .jdo                   (jdo),
    .rd_addr_load          (rd_addr_load),
    .rd_next               (rd_next),
    .tracemem_trcdata      (tracemem_trcdata),
    .tracemem_tw           (tracemem_tw),
    .trc_im_addr           (trc_im_addr),
    .trc_wrap              (trc_wrap),
    .trc_on                (trc_on),
    .tracemem_on           (tracemem_on),
    .trigger_state_1       (trigger_state_1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".trcdata"}, 64'(tracemem_trcdata), 64'd0);
    check_val({tag, ".tw"},      64'(tracemem_tw),      64'd0);
    check_val({tag, ".addr"},    64'(trc_im_addr),      64'd0);
    check_val({tag, ".wrap"},    64'(trc_wrap),         64'd0);
    check_val({tag, ".trc_on"},  64'(trc_on),           64'd0);
    check_val({tag, ".mem_on"},  64'(tracemem_on),      64'd0);
    check_val({tag, ".trig1"},   64'(trigger_state_1),  64'd0);
  endtask

  task automatic ctrl(input logic arm, input logic clr, input logic stp, input logic [7:0] post);
    jdo        = '0;
    jdo[0]     = arm;
    jdo[1]     = clr;
    jdo[2]     = stp;
    jdo[15:8]  = post;
    take_action_tracectrl = 1'b1;
    tick();
    take_action_tracectrl = 1'b0;
    jdo = '0;
  endtask

  task automatic rd_load(input logic [6:0] a);
    jdo = '0;
    jdo[22:16] = a;
    rd_addr_load = 1'b1;
    tick();
    rd_addr_load = 1'b0;
    jdo = '0;
  endtask

  task automatic rd_step();
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
  endtask

  task automatic write_word(input logic [35:0] w);
    trc_word = w;
    trc_word_valid = 1'b1;
    tick();
    trc_word_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    trc_word = '0;
    trc_word_valid = 1'b0;
    trc_trigger = 1'b0;
    take_action_tracectrl = 1'b0;
    jdo = '0;
    rd_addr_load = 1'b0;
    rd_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // Pre-trigger 5 words, trigger, post count 3, then 10 words offered.
    ctrl(1'b1, 1'b0, 1'b0, 8'd3);
    check_val("arm.trc_on", 64'(trc_on), 64'd1);
    check_val("arm.trig1", 64'(trigger_state_1), 64'd0);
    for (int i = 0; i < 5; i++) write_word(PRE + 36'(i));
    trc_trigger = 1'b1;
    tick();
    trc_trigger = 1'b0;
    check_val("trig.trig1", 64'(trigger_state_1), 64'd1);
    trc_word_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      trc_word = POST + 36'(j);
      tick();
    end
    trc_word_valid = 1'b0;
    check_val("post.addr", 64'(trc_im_addr), 64'd8);
    check_val("post.trig1", 64'(trigger_state_1), 64'd0);
    check_val("post.trc_on", 64'(trc_on), 64'd0);
    check_val("post.mem_on", 64'(tracemem_on), 64'd1);
    check_val("post.wrap", 64'(trc_wrap), 64'd0);

    // Load address 3 then two sequential reads.
    rd_load(7'd3);
    check_val("rd3.tw", 64'(tracemem_tw), 64'd1);
    check_val("rd3.data", 64'(tracemem_trcdata), 64'(PRE + 36'd3));
    rd_next = 1'b1;
    tick();
    check_val("rd4.tw", 64'(tracemem_tw), 64'd1);
    check_val("rd4.data", 64'(tracemem_trcdata), 64'(PRE + 36'd4));
    tick();
    rd_next = 1'b0;
    check_val("rd5.tw", 64'(tracemem_tw), 64'd1);
    check_val("rd5.data", 64'(tracemem_trcdata), 64'(POST));
    tick();
    check_val("idle.tw", 64'(tracemem_tw), 64'd0);
    check_val("idle.hold", 64'(tracemem_trcdata), 64'(POST));

    // Read-before-write at the current write address.
    ctrl(1'b1, 1'b1, 1'b0, 8'd0);
    check_val("rearm.addr", 64'(trc_im_addr), 64'd0);
    check_val("rearm.trc_on", 64'(trc_on), 64'd1);
    trc_word = XW;
    trc_word_valid = 1'b1;
    rd_load(7'd0);
    trc_word_valid = 1'b0;
    check_val("rbw.old", 64'(tracemem_trcdata), 64'(PRE));
    rd_load(7'd0);
    check_val("rbw.new", 64'(tracemem_trcdata), 64'(XW));
    check_val("rbw.addr", 64'(trc_im_addr), 64'd1);

    // Clear together with a valid word: word is dropped, state kept.
    trc_word = YW;
    trc_word_valid = 1'b1;
    ctrl(1'b0, 1'b1, 1'b0, 8'd0);
    trc_word_valid = 1'b0;
    check_val("clr.addr", 64'(trc_im_addr), 64'd0);
    check_val("clr.wrap", 64'(trc_wrap), 64'd0);
    check_val("clr.trc_on", 64'(trc_on), 64'd1);
    rd_load(7'd0);
    check_val("clr.mem0", 64'(tracemem_trcdata), 64'(XW));
    rd_step();
    check_val("clr.mem1", 64'(tracemem_trcdata), 64'(PRE + 36'd1));

    // Stop wins over a simultaneous arm.
    ctrl(1'b0, 1'b0, 1'b1, 8'd0);
    ctrl(1'b1, 1'b0, 1'b1, 8'd0);
    check_val("stoparm.trc_on", 64'(trc_on), 64'd0);

    // 130 words with no trigger wraps the buffer.
    ctrl(1'b1, 1'b1, 1'b0, 8'd255);
    trc_word_valid = 1'b1;
    for (int i = 0; i < 130; i++) begin
      trc_word = WX + 36'(i);
      tick();
    end
    trc_word_valid = 1'b0;
    check_val("wrap.addr", 64'(trc_im_addr), 64'd2);
    check_val("wrap.wrap", 64'(trc_wrap), 64'd1);
    check_val("wrap.trc_on", 64'(trc_on), 64'd1);
    check_val("wrap.mem_on", 64'(tracemem_on), 64'd1);
    rd_load(7'd127);
    check_val("wrap.rd127", 64'(tracemem_trcdata), 64'(WX + 36'd127));
    rd_step();
    check_val("wrap.rd0", 64'(tracemem_trcdata), 64'(WX + 36'd128));
    rd_step();
    check_val("wrap.rd1", 64'(tracemem_trcdata), 64'(WX + 36'd129));
    rd_step();
    check_val("wrap.rd2", 64'(tracemem_trcdata), 64'(WX + 36'd2));

    // Post count 0 stops on the first post-trigger write.
    ctrl(1'b0, 1'b0, 1'b1, 8'd0);
    ctrl(1'b1, 1'b1, 1'b0, 8'd0);
    trc_trigger = 1'b1;
    tick();
    trc_trigger = 1'b0;
    check_val("p0.trig1", 64'(trigger_state_1), 64'd1);
    write_word(36'h111);
    check_val("p0.trc_on", 64'(trc_on), 64'd0);
    check_val("p0.addr", 64'(trc_im_addr), 64'd1);
    write_word(36'h222);
    check_val("p0.addr_hold", 64'(trc_im_addr), 64'd1);

    // Asynchronous reset during capture.
    ctrl(1'b1, 1'b1, 1'b0, 8'd10);
    trc_trigger = 1'b1;
    tick();
    trc_trigger = 1'b0;
    for (int i = 0; i < 3; i++) write_word(36'h300 + 36'(i));
    check_val("cap.trig1", 64'(trigger_state_1), 64'd1);
    check_val("cap.addr", 64'(trc_im_addr), 64'd3);
    rd_load(7'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("areset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_val("rel.trc_on", 64'(trc_on), 64'd0);
    check_val("rel.addr", 64'(trc_im_addr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_nios_nios_cpu_trace_capture.md
AUDIO_NIOS_NIOS_CPU_TRACE_CAPTURE -- requirements
Module: audio_nios_Nios_cpu_trace_capture

Interface
REQ-001 SHALL have parameter TRC_DEPTH, default 128, meaning number of trace-buffer entries (power of two; address width 7 at default).
REQ-002 SHALL have port clk, input, 1, sole clock (CPU system clock).
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port trc_word, input, 36, trace word from the CPU trace packer.
REQ-005 SHALL have port trc_word_valid, input, 1, trc_word is valid this cycle.
REQ-006 SHALL have port trc_trigger, input, 1, single-cycle trigger event from the break/trigger logic.
REQ-007 SHALL have port take_action_tracectrl, input, 1, debug control write strobe.
REQ-008 SHALL have port jdo, input, 38, debug data: [0] arm, [1] clear, [2] stop, [15:8] post-trigger count, [22:16] read address.
REQ-009 SHALL have port rd_addr_load, input, 1, load read pointer from jdo[22:16] and read.
REQ-010 SHALL have port rd_next, input, 1, read at read pointer, then increment it.
REQ-011 SHALL have port tracemem_trcdata, output, 36, read-back trace word.
REQ-012 SHALL have port tracemem_tw, output, 1, one-cycle pulse marking tracemem_trcdata valid.
REQ-013 SHALL have port trc_im_addr, output, 7, next write address.
REQ-014 SHALL have port trc_wrap, output, 1, sticky flag: buffer has wrapped.
REQ-015 SHALL have port trc_on, output, 1, high in ARMED or CAPTURE.
REQ-016 SHALL have port tracemem_on, output, 1, high when buffer holds at least one word (trc_im_addr != 0 or trc_wrap).
REQ-017 SHALL have port trigger_state_1, output, 1, high in CAPTURE.

Function
REQ-018 SHALL implement FSM states IDLE, ARMED, CAPTURE, STOPPED.
REQ-019 SHALL move IDLE/STOPPED->ARMED on take_action_tracectrl with jdo[0]=1 and jdo[2]=0.
REQ-020 SHALL move ARMED->CAPTURE on trc_trigger, loading post counter from jdo value latched at arm time.
REQ-021 SHALL decrement the post counter on each write in CAPTURE and move to STOPPED on the write that makes it 0; a count of 0 stops on the first write after trigger.
REQ-022 SHALL move any state->STOPPED on take_action_tracectrl with jdo[2]=1; stop beats arm in the same cycle.
REQ-023 SHALL write trc_word to mem[trc_im_addr] and increment trc_im_addr when trc_word_valid is high in ARMED or CAPTURE (pre- and post-trigger capture).
REQ-024 SHALL wrap trc_im_addr from TRC_DEPTH-1 to 0 and set trc_wrap on that write.
REQ-025 SHALL clear trc_im_addr and trc_wrap on take_action_tracectrl with jdo[1]=1; clear beats a same-cycle write (word discarded) and does not change FSM state.
REQ-026 SHALL perform reads with 1-cycle latency: request in cycle N gives tracemem_trcdata and tracemem_tw=1 in cycle N+1.
REQ-027 SHALL give rd_addr_load priority over rd_next; rd_addr_load sets rd_ptr=jdo[22:16]+1 after reading jdo[22:16].
REQ-028 SHALL return old data on a same-cycle read and write to one address (read-before-write).
REQ-029 SHALL hold tracemem_trcdata between reads; tracemem_tw is low when there is no read.
REQ-030 SHALL wrap rd_ptr modulo TRC_DEPTH.

Reset
REQ-031 SHALL on reset_n low, asynchronously: FSM=IDLE, trc_im_addr=0, trc_wrap=0, rd_ptr=0, post counter=0, tracemem_trcdata=0, tracemem_tw=0; all derived outputs therefore 0.
REQ-032 SHALL leave memory contents undefined after reset; no reset-driven clear of the array.
REQ-033 SHALL abandon a mid-capture operation on reset; nothing is written in the cycle reset releases unless armed.

Verification
REQ-034 SHALL cover: arm, 5 valid words, trigger, post count 3, 10 more valid words -> exactly 8 writes, STOPPED, trc_im_addr=8, trigger_state_1 low.
REQ-035 SHALL cover: arm with post count 255, 130 valid words, no trigger -> trc_im_addr=2, trc_wrap=1, trc_on=1.
REQ-036 SHALL cover: rd_addr_load with jdo[22:16]=3, then 2 rd_next -> tracemem_tw pulses 3 cycles, returning mem[3], mem[4], mem[5].
REQ-037 SHALL cover: clear and valid write in the same cycle -> trc_im_addr=0, trc_wrap=0, word discarded.
REQ-038 SHALL cover: read of address trc_im_addr during a write to it -> previous contents returned.
REQ-039 SHALL cover: reset_n asserted in CAPTURE -> all outputs 0 immediately, no clock edge needed.
